// File: rtl/conv_layer_sched.sv
// conv_layer_sched: output-grid sequencer for the convolution calc block.
// Ports: start/cfg_* launch a layer; win_* address the window source;
// calc_en/calc_en_out/calc_d_out talk to the calc block; out_* is a
// valid/ready result stream; busy/done/err report layer status.
module conv_layer_sched #(
    parameter int N     = 4,
    parameter int M     = 4,
    parameter int E     = 3,
    parameter int ROW_W = 8,
    parameter int COL_W = 8,
    parameter int CH_W  = 6,
    parameter int ACC_W = N + M + E + CH_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ROW_W-1:0]     cfg_rows,
    input  logic [COL_W-1:0]     cfg_cols,
    input  logic [CH_W-1:0]      cfg_ch,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 win_req,
    output logic [ROW_W-1:0]     win_row,
    output logic [COL_W-1:0]     win_col,
    output logic [CH_W-1:0]      win_ch,
    input  logic                 win_valid,
    output logic                 calc_en,
    input  logic                 calc_en_out,
    input  logic [N+M+E-1:0]     calc_d_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_W-1:0]     out_data,
    output logic [ROW_W-1:0]     out_row,
    output logic [COL_W-1:0]     out_col,
    output logic                 out_last
);

    localparam logic [ROW_W-1:0] ROW_ONE = 1;
    localparam logic [COL_W-1:0] COL_ONE = 1;
    localparam logic [CH_W-1:0]  CH_ONE  = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_OUTPUT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [ROW_W-1:0]   rows_q, rows_d;
    logic [COL_W-1:0]   cols_q, cols_d;
    logic [CH_W-1:0]    ch_eff_q, ch_eff_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic [CH_W-1:0]    ret_q, ret_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               win_req_q, win_req_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_data_q, out_data_d;
    logic [ROW_W-1:0]   out_row_q, out_row_d;
    logic [COL_W-1:0]   out_col_q, out_col_d;
    logic               out_last_q, out_last_d;
    logic               ret_room;
    logic               pos_last;

    always_comb begin
        state_d     = state_q;
        rows_d      = rows_q;
        cols_d      = cols_q;
        ch_eff_d    = ch_eff_q;
        row_d       = row_q;
        col_d       = col_q;
        ch_d        = ch_q;
        ret_d       = ret_q;
        acc_d       = acc_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
        out_last_d  = out_last_q;
        ret_room    = (ret_q != ch_eff_q);
        pos_last    = (row_q == rows_q - ROW_ONE) &&
                      (col_q == cols_q - COL_ONE);

        // Strobes are only accepted while a position is in flight and
        // fewer than ch_eff have come back; anything else is a fault.
        if (calc_en_out) begin
            if ((state_q == S_ISSUE || state_q == S_DRAIN) && ret_room) begin
                acc_d = acc_q + ACC_W'($signed(calc_d_out));
                ret_d = ret_q + CH_ONE;
            end else begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rows_d   = cfg_rows;
                    cols_d   = cfg_cols;
                    ch_eff_d = (cfg_ch == '0) ? CH_ONE : cfg_ch;
                    err_d    = 1'b0;
                    row_d    = '0;
                    col_d    = '0;
                    ch_d     = '0;
                    ret_d    = '0;
                    acc_d    = '0;
                    if (cfg_rows == '0 || cfg_cols == '0)
                        state_d = S_DONE;
                    else
                        state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (win_valid) begin
                    ch_d = ch_q + CH_ONE;
                    if (ch_q == ch_eff_q - CH_ONE)
                        state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // ret_d/acc_d already include a strobe landing this cycle.
                if (ret_d == ch_eff_q) begin
                    out_valid_d = 1'b1;
                    out_data_d  = acc_d;
                    out_row_d   = row_q;
                    out_col_d   = col_q;
                    out_last_d  = pos_last;
                    state_d     = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    acc_d       = '0;
                    ret_d       = '0;
                    ch_d        = '0;
                    if (col_q == cols_q - COL_ONE) begin
                        col_d = '0;
                        row_d = row_q + ROW_ONE;
                    end else begin
                        col_d = col_q + COL_ONE;
                    end
                    state_d = out_last_q ? S_DONE : S_ISSUE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status outputs are registered from the next state so they line
        // up with the state they describe.
        win_req_d = (state_d == S_ISSUE);
        busy_d    = (state_d == S_ISSUE) || (state_d == S_DRAIN) ||
                    (state_d == S_OUTPUT);
        done_d    = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rows_q      <= '0;
            cols_q      <= '0;
            ch_eff_q    <= '0;
            row_q       <= '0;
            col_q       <= '0;
            ch_q        <= '0;
            ret_q       <= '0;
            acc_q       <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            win_req_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rows_q      <= rows_d;
            cols_q      <= cols_d;
            ch_eff_q    <= ch_eff_d;
            row_q       <= row_d;
            col_q       <= col_d;
            ch_q        <= ch_d;
            ret_q       <= ret_d;
            acc_q       <= acc_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            win_req_q   <= win_req_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            out_last_q  <= out_last_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign win_req   = win_req_q;
    assign win_row   = row_q;
    assign win_col   = col_q;
    assign win_ch    = ch_q;
    assign calc_en   = win_req_q & win_valid;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_conv_layer_sched.sv
// tb_conv_layer_sched: directed checks of conv_layer_sched with a
// latency-1 calc responder driven from the stimulus tick task.
module tb_conv_layer_sched;

    localparam int N     = 4;
    localparam int M     = 4;
    localparam int E     = 3;
    localparam int ROW_W = 8;
    localparam int COL_W = 8;
    localparam int CH_W  = 6;
    localparam int RW    = N + M + E;
    localparam int ACC_W = RW + CH_W;

    logic             clk;
    logic             rst;
    logic             start;
    logic [ROW_W-1:0] cfg_rows;
    logic [COL_W-1:0] cfg_cols;
    logic [CH_W-1:0]  cfg_ch;
    logic             busy;
    logic             done;
    logic             err;
    logic             win_req;
    logic [ROW_W-1:0] win_row;
    logic [COL_W-1:0] win_col;
    logic [CH_W-1:0]  win_ch;
    logic             win_valid;
    logic             calc_en;
    logic             calc_en_out;
    logic [RW-1:0]    calc_d_out;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic [ROW_W-1:0] out_row;
    logic [COL_W-1:0] out_col;
    logic             out_last;

    conv_layer_sched #(
        .N(N), .M(M), .E(E), .ROW_W(ROW_W), .COL_W(COL_W),
        .CH_W(CH_W), .ACC_W(ACC_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_rows(cfg_rows), .cfg_cols(cfg_cols), .cfg_ch(cfg_ch),
        .busy(busy), .done(done), .err(err),
        .win_req(win_req), .win_row(win_row), .win_col(win_col),
        .win_ch(win_ch), .win_valid(win_valid), .calc_en(calc_en),
        .calc_en_out(calc_en_out), .calc_d_out(calc_d_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_row(out_row), .out_col(out_col),
        .out_last(out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int rows;
        int cols;
        int ch;
        int val;
        int exp_busy1;
        int exp_outs;
        int exp_data;
        int exp_cen;
        int exp_gap;
    } vec_t;

    vec_t          tv [6];
    int            tests;
    int            fails;
    int            cyc;
    int            n_cen;
    int            cval;
    int            vals [$];
    bit            inj;
    logic [RW-1:0] inj_val;
    logic          last_fire;

    task automatic check(input string nm, input logic [63:0] got,
                         input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d",
                     nm, $signed(got), $signed(exp));
        end
    endtask

    function automatic int sx(input logic [ACC_W-1:0] v);
        return int'($signed(v));
    endfunction

    // One clock: sample calc_en before the edge, then after the edge
    // return one calc result for each fired beat (latency 1).
    task automatic tick();
        logic fire;
        #1;
        fire = calc_en;
        last_fire = fire;
        if (fire) n_cen++;
        @(posedge clk);
        #1;
        cyc++;
        if (fire) begin
            calc_en_out = 1'b1;
            if (vals.size() > 0) calc_d_out = RW'(vals.pop_front());
            else calc_d_out = RW'(cval);
        end else if (inj) begin
            calc_en_out = 1'b1;
            calc_d_out  = inj_val;
            inj         = 1'b0;
        end else begin
            calc_en_out = 1'b0;
            calc_d_out  = '0;
        end
    endtask

    task automatic start_layer(input int r, input int c, input int ch);
        cfg_rows = ROW_W'(r);
        cfg_cols = COL_W'(c);
        cfg_ch   = CH_W'(ch);
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_valid(input string nm);
        for (int k = 0; k < 100 && !out_valid; k++) tick();
        check(nm, out_valid, 1);
    endtask

    task automatic wait_done(input string nm);
        for (int k = 0; k < 100 && !done; k++) tick();
        check(nm, done, 1);
        tick();
    endtask

    initial begin
        int er, ec, prev, done_at, t0, n_out, nb, snap;
        int pat [6];
        int exp_wch [6];
        pat     = '{1, 0, 0, 1, 0, 1};
        exp_wch = '{0, 1, 1, 1, 2, 2};

        tests = 0; fails = 0; cyc = 0; n_cen = 0; cval = 0;
        inj = 1'b0; inj_val = '0; last_fire = 1'b0;
        rst = 1'b1; start = 1'b0;
        cfg_rows = '0; cfg_cols = '0; cfg_ch = '0;
        win_valid = 1'b0; calc_en_out = 1'b0; calc_d_out = '0;
        out_ready = 1'b0;

        tick();
        tick();
        check("rst_flags", {busy, done, err, win_req, calc_en,
                            out_valid, out_last}, 0);
        check("rst_data", out_data, 0);
        check("rst_addr", {out_row, out_col, win_row, win_col, win_ch}, 0);
        rst = 1'b0;
        tick();

        //         rows cols ch val  busy1 outs data  cen gap
        tv[0] = '{2, 2, 1, 5,     1, 4, 5,     4, 3};
        tv[1] = '{1, 3, 2, -3,    1, 3, -6,    6, 4};
        tv[2] = '{2, 1, 0, 7,     1, 2, 7,     2, 3};
        tv[3] = '{0, 3, 2, 1,     0, 0, 0,     0, 0};
        tv[4] = '{3, 0, 1, 1,     0, 0, 0,     0, 0};
        tv[5] = '{1, 1, 4, -1024, 1, 1, -4096, 4, 6};

        for (int i = 0; i < 6; i++) begin
            vals.delete();
            cval      = tv[i].val;
            out_ready = 1'b1;
            win_valid = 1'b1;
            n_cen     = 0;
            n_out     = 0;
            er = 0; ec = 0; prev = -1; done_at = -1;
            t0 = cyc;
            start_layer(tv[i].rows, tv[i].cols, tv[i].ch);
            check("busy_t1", busy, tv[i].exp_busy1);
            check("req_t1", win_req, tv[i].exp_busy1);
            for (int k = 0; k < 300 && done_at < 0; k++) begin
                if (out_valid) begin
                    check("v_data", sx(out_data), tv[i].exp_data);
                    check("v_pos", {out_row, out_col},
                          {ROW_W'(er), COL_W'(ec)});
                    check("v_last", out_last,
                          (er == tv[i].rows - 1) && (ec == tv[i].cols - 1));
                    if (prev >= 0) check("v_gap", cyc - prev, tv[i].exp_gap);
                    prev = cyc;
                    n_out++;
                    ec++;
                    if (ec == tv[i].cols) begin
                        ec = 0;
                        er++;
                    end
                end
                if (done) begin
                    done_at = cyc;
                    check("v_busy_at_done", busy, 0);
                end
                if (done_at < 0) tick();
            end
            check("v_done_seen", done_at >= 0, 1);
            check("v_outs", n_out, tv[i].exp_outs);
            check("v_cen", n_cen, tv[i].exp_cen);
            if (tv[i].exp_outs > 0) check("v_done_t", done_at, prev + 1);
            else check("v_done_t", done_at, t0 + 1);
            tick();
        end

        // Signed sum of mixed results over three channels.
        vals.delete();
        vals.push_back(-7);
        vals.push_back(2);
        vals.push_back(-1);
        n_cen = 0;
        start_layer(1, 1, 3);
        wait_valid("A_valid");
        check("A_data", out_data, 17'h1fffa);
        check("A_cen", n_cen, 3);
        check("A_last", out_last, 1);
        tick();
        wait_done("A_done");

        // Backpressure on the first output, with a start pulse ignored.
        cval = 4;
        out_ready = 1'b0;
        n_cen = 0;
        start_layer(1, 2, 1);
        wait_valid("B_valid");
        snap = n_cen;
        for (int j = 0; j < 5; j++) begin
            check("B_hold_v", out_valid, 1);
            check("B_hold_d", sx(out_data), 4);
            check("B_hold_pos", {out_row, out_col}, 0);
            check("B_no_req", win_req, 0);
            if (j == 1) begin
                cfg_rows = 8'd7;
                start = 1'b1;
            end
            tick();
            start = 1'b0;
        end
        check("B_no_cen", n_cen, snap);
        out_ready = 1'b1;
        tick();
        nb = 1;
        for (int k = 0; k < 100 && !done; k++) begin
            if (out_valid) nb++;
            tick();
        end
        check("B_done", done, 1);
        check("B_outs", nb, 2);
        tick();

        // Gapped win_valid: issues only on high cycles, win_ch holds.
        vals.delete();
        vals.push_back(1);
        vals.push_back(2);
        vals.push_back(3);
        n_cen = 0;
        start_layer(1, 1, 3);
        for (int j = 0; j < 6; j++) begin
            win_valid = pat[j][0];
            check("C_wch", win_ch, exp_wch[j]);
            check("C_req", win_req, 1);
            tick();
            check("C_en", last_fire, pat[j]);
        end
        win_valid = 1'b1;
        wait_valid("C_valid");
        check("C_data", sx(out_data), 6);
        check("C_cen", n_cen, 3);
        tick();
        wait_done("C_done");

        // Reset while draining.
        cval = 5;
        start_layer(1, 1, 1);
        tick();
        check("D_drain", {busy, win_req}, 2'b10);
        rst = 1'b1;
        tick();
        check("D_rst_flags", {busy, done, err, win_req, calc_en,
                              out_valid, out_last}, 0);
        check("D_rst_data", {out_data, out_row, out_col,
                             win_row, win_col, win_ch}, 0);
        rst = 1'b0;
        tick();

        // Stray strobe while the result is held.
        cval = 9;
        out_ready = 1'b0;
        start_layer(1, 1, 1);
        wait_valid("E_valid");
        inj_val = RW'(100);
        inj = 1'b1;
        tick();
        tick();
        check("E_err", err, 1);
        check("E_data", sx(out_data), 9);
        check("E_hold_v", out_valid, 1);
        out_ready = 1'b1;
        tick();
        wait_done("E_done");
        check("E_err_sticky", err, 1);
        start_layer(1, 1, 1);
        check("E_err_clr", err, 0);
        wait_valid("E2_valid");
        check("E2_data", sx(out_data), 9);
        tick();
        wait_done("E2_done");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
